alu_pipe: RTL and testbench

Parametrised, registered successor to the 16-bit combinational ALU: same opcode encoding and Z/R flag semantics, generalised to WIDTH bits. It adds a valid/ready handshake, architectural flag registers, carry/borrow-chained ops, a compare op, and an optional iterative multiplier. It sits between the register-read stage and writeback, so the execute stage can be stalled by downstream backpressure.

---
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
//   master: producer of operands and consumer of results (drives in_valid, a, b, oper,
//           out_ready).
//   slave:  the ALU (drives in_ready, out_valid, c, z, r, wr, flag_z, flag_r).
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       oper;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             z;
  logic             r;
  logic             wr;
  logic             flag_z;
  logic             flag_r;

  modport master (
    output in_valid, a, b, oper, out_ready,
    input  in_ready, out_valid, c, z, r, wr, flag_z, flag_r
  );

  modport slave (
    input  in_valid, a, b, oper, out_ready,
    output in_ready, out_valid, c, z, r, wr, flag_z, flag_r
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshake and architectural
// Z/R flags. Opcodes: 1100 ADD, 1101 ADC, 1000 SUB, 1001 SBB, 1010 CMP, 0010 NAND;
// anything else yields c=0, z=1, r=0, wr=0 and leaves the flags alone.
// Optional feature: define ALU_MUL_EN to add opcode 0011 MUL, an iterative shift-add
// multiplier taking WIDTH cycles (one partial product per cycle).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_pipe_if slave: in_valid/in_ready/a/b/oper in, out_valid/out_ready/c/z/r/wr
//          out, plus flag_z/flag_r. All outputs except in_ready are registers; in_ready
//          depends combinationally on out_ready only.
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  localparam logic [3:0] OpAdd  = 4'b1100;
  localparam logic [3:0] OpAdc  = 4'b1101;
  localparam logic [3:0] OpSub  = 4'b1000;
  localparam logic [3:0] OpSbb  = 4'b1001;
  localparam logic [3:0] OpCmp  = 4'b1010;
  localparam logic [3:0] OpNand = 4'b0010;
`ifdef ALU_MUL_EN
  localparam logic [3:0]  OpMul = 4'b0011;
  localparam int unsigned CntW  = $clog2(WIDTH);
`endif

  typedef enum logic [1:0] {
    StIdle,
    StHold
`ifdef ALU_MUL_EN
    ,
    StMul
`endif
  } state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] c_q;
  logic             z_q;
  logic             r_q;
  logic             wr_q;
  logic             flag_z_q;
  logic             flag_r_q;

  logic             busy;
  logic             in_ready;
  logic             accept;

  // Single-cycle datapath
  logic             cin;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] res;
  logic             res_z;
  logic             res_r;
  logic             res_wr;
  logic             res_fw;

  // Only ADC/SBB chain through the carry flag
  assign cin     = ((bus.oper == OpAdc) || (bus.oper == OpSbb)) ? flag_r_q : 1'b0;
  assign sum_ext = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
  // Bit WIDTH of the extended difference is the borrow out
  assign dif_ext = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cin};

  always_comb begin
    res    = '0;
    res_r  = 1'b0;
    res_wr = 1'b0;
    res_fw = 1'b0;
    case (bus.oper)
      OpAdd: begin
        res    = sum_ext[WIDTH-1:0];
        res_wr = 1'b1;
        res_fw = 1'b1;
      end
      OpAdc: begin
        res    = sum_ext[WIDTH-1:0];
        res_r  = sum_ext[WIDTH];
        res_wr = 1'b1;
        res_fw = 1'b1;
      end
      OpSub, OpSbb: begin
        res    = dif_ext[WIDTH-1:0];
        res_r  = dif_ext[WIDTH];
        res_wr = 1'b1;
        res_fw = 1'b1;
      end
      OpCmp: begin
        res    = dif_ext[WIDTH-1:0];
        res_r  = dif_ext[WIDTH];
        res_fw = 1'b1;
      end
      OpNand: begin
        res    = ~(bus.a & bus.b);
        res_wr = 1'b1;
        res_fw = 1'b1;
      end
      default: ;
    endcase
  end

  assign res_z = (res == '0);

`ifdef ALU_MUL_EN
  // prod_q = {accumulator, remaining multiplier bits}; each step conditionally adds the
  // multiplicand into the upper half and shifts the whole product right by one.
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   mul_lo;

  assign mul_add   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {mul_add, prod_q[WIDTH-1:1]};
  assign mul_lo    = prod_step[WIDTH-1:0];
  assign busy      = (state_q == StMul);
`else
  assign busy      = 1'b0;
`endif

  assign in_ready = !busy && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      z_q         <= 1'b0;
      r_q         <= 1'b0;
      wr_q        <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_r_q    <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (bus.oper == OpMul) begin
              state_q     <= StMul;
              out_valid_q <= 1'b0;
              mcand_q     <= bus.a;
              prod_q      <= {{WIDTH{1'b0}}, bus.b};
              cnt_q       <= CntW'(WIDTH - 1);
            end else
`endif
            begin
              state_q     <= StHold;
              out_valid_q <= 1'b1;
              c_q         <= res;
              z_q         <= res_z;
              r_q         <= res_r;
              wr_q        <= res_wr;
              if (res_fw) begin
                flag_z_q <= res_z;
                flag_r_q <= res_r;
              end
            end
          end else if ((state_q == StHold) && bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        StMul: begin
          prod_q <= prod_step;
          if (cnt_q == '0) begin
            // Last partial product: the result and the flags load together
            state_q     <= StHold;
            out_valid_q <= 1'b1;
            c_q         <= mul_lo;
            z_q         <= (mul_lo == '0);
            r_q         <= |prod_step[2*WIDTH-1:WIDTH];
            wr_q        <= 1'b1;
            flag_z_q    <= (mul_lo == '0);
            flag_r_q    <= |prod_step[2*WIDTH-1:WIDTH];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.z         = z_q;
  assign bus.r         = r_q;
  assign bus.wr        = wr_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_r    = flag_r_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed literal checks plus randomized traffic against a behavioural
// model of alu_pipe (WIDTH=16). Works with or without ALU_MUL_EN defined.
module tb_alu_pipe;
  localparam int unsigned W = 16;
`ifdef ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference semantics from the opcode table, in plain integer arithmetic
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit fr,
                                 output logic [W-1:0] c, output bit r, output bit wr,
                                 output bit fw);
    longint unsigned m = 64'd1 << W;
    longint unsigned x = a;
    longint unsigned y = b;
    longint unsigned t = 0;
    r  = 1'b0;
    wr = 1'b0;
    fw = 1'b0;
    case (op)
      4'b1100: begin t = (x + y) % m; wr = 1; fw = 1; end
      4'b1101: begin t = x + y + fr; r = (t >= m); t = t % m; wr = 1; fw = 1; end
      4'b1000: begin t = (x + m - y) % m; r = (x < y); wr = 1; fw = 1; end
      4'b1010: begin t = (x + m - y) % m; r = (x < y); fw = 1; end
      4'b1001: begin t = (x + 2 * m - y - fr) % m; r = (x < y + fr); wr = 1; fw = 1; end
      4'b0010: begin t = (m - 1) - (x & y); wr = 1; fw = 1; end
      4'b0011: begin
        if (MulEn) begin
          t = x * y; r = ((t / m) != 0); t = t % m; wr = 1; fw = 1;
        end
      end
      default: ;
    endcase
    c = t[W-1:0];
  endfunction

  // Behavioural model state
  bit           m_valid = 0;
  logic [W-1:0] m_c = '0;
  bit           m_z = 0, m_r = 0, m_wr = 0, m_fz = 0, m_fr = 0;
  int           m_mul_left = 0;
  logic [W-1:0] m_mul_c = '0;
  bit           m_mul_r = 0;

  logic [W-1:0] r_c;
  bit           r_r, r_wr, r_fw;
  always_comb ref_op(bus.oper, bus.a, bus.b, m_fr, r_c, r_r, r_wr, r_fw);

  function automatic bit m_in_ready();
    return (m_mul_left == 0) && (!m_valid || bus.out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_c <= '0; m_z <= 0; m_r <= 0; m_wr <= 0;
      m_fz <= 0; m_fr <= 0; m_mul_left <= 0;
    end else if (m_mul_left > 0) begin
      if (m_mul_left == 1) begin
        m_valid <= 1; m_c <= m_mul_c; m_z <= (m_mul_c == '0); m_r <= m_mul_r; m_wr <= 1;
        m_fz <= (m_mul_c == '0); m_fr <= m_mul_r;
      end
      m_mul_left <= m_mul_left - 1;
    end else if (bus.in_valid && m_in_ready()) begin
      if (MulEn && bus.oper == 4'b0011) begin
        m_valid <= 0; m_mul_left <= W; m_mul_c <= r_c; m_mul_r <= r_r;
      end else begin
        m_valid <= 1; m_c <= r_c; m_z <= (r_c == '0); m_r <= r_r; m_wr <= r_wr;
        if (r_fw) begin
          m_fz <= (r_c == '0); m_fr <= r_r;
        end
      end
    end else if (bus.out_ready) begin
      m_valid <= 0;
    end
  end

  // Compare process: registered outputs sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("m.in_ready", 64'(bus.in_ready), 64'(m_in_ready()));
      chk("m.flag_z", 64'(bus.flag_z), 64'(m_fz));
      chk("m.flag_r", 64'(bus.flag_r), 64'(m_fr));
      if (m_valid) begin
        chk("m.c", 64'(bus.c), 64'(m_c));
        chk("m.z", 64'(bus.z), 64'(m_z));
        chk("m.r", 64'(bus.r), 64'(m_r));
        chk("m.wr", 64'(bus.wr), 64'(m_wr));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.oper     = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic res_chk(input string name, input logic [W-1:0] c, input bit z, input bit r,
                         input bit wr);
    chk({name, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, ".c"}, 64'(bus.c), 64'(c));
    chk({name, ".z"}, 64'(bus.z), 64'(z));
    chk({name, ".r"}, 64'(bus.r), 64'(r));
    chk({name, ".wr"}, 64'(bus.wr), 64'(wr));
  endtask

  task automatic zero_chk(input string name);
    chk({name, ".valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, ".c"}, 64'(bus.c), 64'd0);
    chk({name, ".zrw"}, 64'({bus.z, bus.r, bus.wr}), 64'd0);
    chk({name, ".flags"}, 64'({bus.flag_z, bus.flag_r}), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_word();
    int unsigned k = $urandom_range(0, 7);
    if (k == 0) return '0;
    if (k == 1) return '1;
    return W'($urandom);
  endfunction

  initial begin
    logic [3:0] ops [9];
    ops = '{4'b1100, 4'b1101, 4'b1000, 4'b1001, 4'b1010, 4'b0010, 4'b0011, 4'b0111, 4'b1111};
    bus.in_valid = 0; bus.oper = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1;

    repeat (3) cyc();
    zero_chk("reset");
    chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    issue(4'b1100, 16'hFFFF, 16'h0001); cyc();
    res_chk("add_wrap", 16'h0000, 1, 0, 1);
    issue(4'b1000, 16'h0003, 16'h0005); cyc();
    res_chk("sub", 16'hFFFE, 0, 1, 1);
    chk("sub.flag_r", 64'(bus.flag_r), 64'd1);
    issue(4'b1001, 16'h0000, 16'h0000); cyc();
    res_chk("sbb", 16'hFFFF, 0, 1, 1);
    issue(4'b0111, 16'h0005, 16'h0007); cyc();
    res_chk("undef", 16'h0000, 1, 0, 0);
    chk("undef.flags", 64'({bus.flag_z, bus.flag_r}), 64'b01);
    issue(4'b1010, 16'h1234, 16'h1234); cyc();
    res_chk("cmp", 16'h0000, 1, 0, 0);
    chk("cmp.flags", 64'({bus.flag_z, bus.flag_r}), 64'b10);
    issue(4'b1000, 16'h0000, 16'h0001); cyc();
    issue(4'b1101, 16'h8080, 16'h8080); cyc();
    res_chk("adc", 16'h0101, 0, 1, 1);

    issue(4'b0010, 16'h00FF, 16'h0F0F); cyc();
    res_chk("nand", 16'hFFF0, 0, 0, 1);
    bus.out_ready = 0;
    issue(4'b1100, 16'h0001, 16'h0002);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp.in_ready", 64'(bus.in_ready), 64'd0);
      cyc();
      res_chk("bp.hold", 16'hFFF0, 0, 0, 1);
    end
    bus.out_ready = 1;
    #1;
    chk("bp.release", 64'(bus.in_ready), 64'd1);
    cyc();
    res_chk("bp.next", 16'h0003, 0, 0, 1);
    bus.in_valid = 0;
    cyc();
    chk("drain", 64'(bus.out_valid), 64'd0);

    if (MulEn) begin
      issue(4'b0011, 16'h0100, 16'h0100); cyc();
      issue(4'b1100, 16'h0001, 16'h0001);
      for (int i = 0; i < W; i++) begin
        chk("mul.wait_valid", 64'(bus.out_valid), 64'd0);
        chk("mul.wait_ready", 64'(bus.in_ready), 64'd0);
        cyc();
      end
      res_chk("mul", 16'h0000, 1, 1, 1);
      chk("mul.flags", 64'({bus.flag_z, bus.flag_r}), 64'b11);
      bus.in_valid = 0;
      cyc();
      issue(4'b0011, 16'h00FF, 16'h0003); cyc();
      bus.in_valid = 0;
      repeat (5) cyc();
    end else begin
      issue(4'b0011, 16'h0100, 16'h0100); cyc();
      res_chk("mul_off", 16'h0000, 1, 0, 0);
      bus.in_valid = 0;
    end
    #2 rst_n = 1'b0;
    #1 zero_chk("midrst");
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      cyc();
      chk("midrst.no_result", 64'(bus.out_valid), 64'd0);
    end

    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.oper      = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) bus.oper = 4'($urandom);
      bus.a = rnd_word();
      bus.b = rnd_word();
      cyc();
    end
    bus.in_valid  = 0;
    bus.out_ready = 1;
    repeat (W + 4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
